// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator: FSM state encoding
// and the operand-count threshold beyond which the group sum may have wrapped.
package csa_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_HOLD    = 2'd2
  } csa_state_e;

  // Summing more than 2^(acc_width-in_width) full-scale operands can overflow.
  function automatic longint unsigned csa_guard_threshold(input int in_width,
                                                          input int acc_width);
    return 64'd1 << (acc_width - in_width);
  endfunction

endpackage

// File: rtl/csa_3to2_uniform.sv
// Equal-width 3:2 compressor: bitwise full adders, carries shifted up one bit
// with the carry out of the top bit dropped.
module csa_3to2_uniform #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Streaming group accumulator: operands are folded into redundant sum/carry
// form, resolved with one carry-propagate add after the last operand, then held.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int ACC_WIDTH   = 20,
  parameter int SIGNED_MODE = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_guard,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a held valid keeps its data.

  localparam int EXT_W = ACC_WIDTH - IN_WIDTH;
  localparam int GW    = EXT_W + 1;
  localparam logic [GW-1:0] GUARD_THR = GW'(csa_guard_threshold(IN_WIDTH, ACC_WIDTH));

  csa_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [ACC_WIDTH-1:0] carry_q, carry_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_guard_q, out_guard_d;

  logic                 ext_bit;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] csa_sum;
  logic [ACC_WIDTH-1:0] csa_carry;

  assign ext_bit = (SIGNED_MODE != 0) ? in_data[IN_WIDTH-1] : 1'b0;
  assign in_ext  = {{EXT_W{ext_bit}}, in_data};

  csa_3to2_uniform #(.W(ACC_WIDTH)) u_csa (
    .a     (sum_q),
    .b     (carry_q),
    .c     (in_ext),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // gcnt tracks the true term count past the point where cnt saturates,
  // so the guard stays correct even when CNT_WIDTH is narrow.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_guard_d = out_guard_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          sum_d   = csa_sum;
          carry_d = csa_carry;
          if (!(&cnt_q))  cnt_d  = cnt_q + CNT_WIDTH'(1);
          if (!(&gcnt_q)) gcnt_d = gcnt_q + GW'(1);
          if (in_last)    state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        out_data_d  = sum_q + carry_q;
        out_count_d = cnt_q;
        out_guard_d = (gcnt_q > GUARD_THR);
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          gcnt_d  = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_guard_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_guard_q <= out_guard_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_guard = out_guard_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: an unsigned and a signed instance share one
// stimulus stream; results are checked against an arithmetic group-sum model.
module tb_csa_accumulator;
  import csa_pkg::*;

  localparam int IW = 12;
  localparam int AW = 20;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready_u, out_valid_u, out_guard_u;
  logic [AW-1:0] out_data_u;
  logic [CW-1:0] out_count_u;
  logic [1:0]    dbg_state_u;
  logic          in_ready_s, out_valid_s, out_guard_s;
  logic [AW-1:0] out_data_s;
  logic [CW-1:0] out_count_s;
  logic [1:0]    dbg_state_s;

  csa_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SIGNED_MODE(0), .CNT_WIDTH(CW)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_count(out_count_u), .out_guard(out_guard_u), .dbg_state(dbg_state_u));

  csa_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SIGNED_MODE(1), .CNT_WIDTH(CW)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_count(out_count_s), .out_guard(out_guard_s), .dbg_state(dbg_state_s));

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_err = 0;
  int            n_results = 0;
  logic [AW-1:0] exp_u_q[$];
  logic [AW-1:0] exp_s_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic          exp_guard_q[$];
  logic [IW-1:0] ops_q[$];
  bit            rand_ready = 1'b0;

  logic [AW-1:0] last_u, last_s;
  logic [CW-1:0] last_cnt;
  logic          last_guard;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            hold_pend = 1'b0;
  bit            last_seen = 1'b0;
  longint        last_cyc = 0;
  logic [AW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid_u), 64'd1);
        chk("hold_data", 64'(out_data_u), 64'(hold_data));
      end
      if (out_valid_u) chk("hold_in_ready", 64'(in_ready_u), 64'd0);
      if (out_valid_u && last_seen) begin
        chk("latency", 64'(cyc - last_cyc), 64'd2);
        last_seen = 1'b0;
      end
      if (in_valid && in_ready_u && in_last) begin
        last_seen = 1'b1;
        last_cyc  = cyc;
      end
      if (out_valid_u && out_ready) begin
        if (exp_u_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          logic [AW-1:0] eu, es;
          logic [CW-1:0] ec;
          logic          eg;
          eu = exp_u_q.pop_front();
          es = exp_s_q.pop_front();
          ec = exp_cnt_q.pop_front();
          eg = exp_guard_q.pop_front();
          chk("sum_unsigned", 64'(out_data_u), 64'(eu));
          chk("sum_signed", 64'(out_data_s), 64'(es));
          chk("count", 64'(out_count_u), 64'(ec));
          chk("guard", 64'(out_guard_u), 64'(eg));
          last_u     = out_data_u;
          last_s     = out_data_s;
          last_cnt   = out_count_u;
          last_guard = out_guard_u;
          n_results++;
        end
      end
      hold_pend = out_valid_u && !out_ready;
      hold_data = out_data_u;
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic [IW-1:0] d, input logic last, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = IW'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready_u) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Model: the group sum is plain integer addition of the extended operands.
  task automatic send_group(input bit push, input bit gaps, input bit with_last);
    longint su, ss, n;
    logic signed [IW-1:0] sd;
    su = 0;
    ss = 0;
    n  = ops_q.size();
    foreach (ops_q[i]) begin
      sd = ops_q[i];
      su = su + longint'(ops_q[i]);
      ss = ss + longint'(sd);
    end
    if (push && with_last) begin
      exp_u_q.push_back(su[AW-1:0]);
      exp_s_q.push_back(ss[AW-1:0]);
      exp_cnt_q.push_back((n > 255) ? CW'(255) : CW'(n));
      exp_guard_q.push_back(n > 256);
    end
    foreach (ops_q[i]) send_op(ops_q[i], with_last && (i == ops_q.size() - 1), gaps);
  endtask

  task automatic fill_const(input int n, input logic [IW-1:0] v);
    ops_q.delete();
    for (int i = 0; i < n; i++) ops_q.push_back(v);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid_u) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_valid_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000; t++) begin
      if (exp_u_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", 64'(exp_u_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reset is asserted together with a would-be last handshake to show rst wins.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = IW'($urandom);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("rst_in_ready", 64'(in_ready_u), 64'd1);
    chk("rst_out_valid", 64'(out_valid_u), 64'd0);
    chk("rst_out_data", 64'(out_data_u), 64'd0);
    chk("rst_out_data_s", 64'(out_data_s), 64'd0);
    chk("rst_out_count", 64'(out_count_u), 64'd0);
    chk("rst_out_guard", 64'(out_guard_u), 64'd0);
    chk("rst_state", 64'(dbg_state_u), 64'(ST_ACCUM));
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_emit", 64'(out_valid_s), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;

    // 100 + 200 + 300
    ops_q = '{12'd100, 12'd200, 12'd300};
    send_group(1, 0, 1);
    wait_drain();
    chk("basic_sum", 64'(last_u), 64'd600);
    chk("basic_count", 64'(last_cnt), 64'd3);
    chk("basic_guard", 64'(last_guard), 64'd0);

    // -5 + 3 in signed mode
    ops_q = '{12'hFFB, 12'd3};
    send_group(1, 0, 1);
    wait_drain();
    chk("signed_sum", 64'(last_s), 64'h00000FFFFE);
    chk("signed_count", 64'(last_cnt), 64'd2);

    // single-operand group
    ops_q = '{12'hABC};
    send_group(1, 0, 1);
    wait_drain();
    chk("single_u", 64'(last_u), 64'h00ABC);
    chk("single_s", 64'(last_s), 64'hFFABC);

    // 300 x 0xFFF: wraps, counter saturates, guard set
    fill_const(300, 12'hFFF);
    send_group(1, 0, 1);
    wait_drain();
    chk("sat_sum", 64'(last_u), 64'd179924);
    chk("sat_count", 64'(last_cnt), 64'd255);
    chk("sat_guard", 64'(last_guard), 64'd1);

    // guard threshold boundary
    fill_const(256, 12'hFFF);
    send_group(1, 0, 1);
    wait_drain();
    chk("guard_256", 64'(last_guard), 64'd0);
    fill_const(257, 12'h001);
    send_group(1, 0, 1);
    wait_drain();
    chk("guard_257", 64'(last_guard), 64'd1);

    // back-pressure in HOLD, with a blocked last operand waiting
    out_ready = 1'b0;
    ops_q = '{12'd9};
    send_group(1, 0, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 12'd7;
      in_last  = 1'b1;
      @(negedge clk);
      chk("stall_valid", 64'(out_valid_u), 64'd1);
      chk("stall_data", 64'(out_data_u), 64'd9);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    ops_q = '{12'd7};
    send_group(1, 0, 1);
    wait_drain();
    chk("after_stall", 64'(last_u), 64'd7);

    // reset mid-group discards the partial sum
    base = n_results;
    ops_q = '{12'd11, 12'd22};
    send_group(0, 0, 0);
    do_reset();
    ops_q = '{12'd1, 12'd2};
    send_group(1, 0, 1);
    wait_drain();
    chk("midrst_sum", 64'(last_u), 64'd3);
    chk("midrst_count", 64'(last_cnt), 64'd2);
    chk("midrst_results", 64'(n_results - base), 64'd1);

    // reset while holding a result discards it
    out_ready = 1'b0;
    ops_q = '{12'd5};
    send_group(0, 0, 1);
    wait_valid();
    do_reset();
    out_ready = 1'b1;
    ops_q = '{12'd4};
    send_group(1, 0, 1);
    wait_drain();
    chk("holdrst_sum", 64'(last_u), 64'd4);

    // randomized groups with source gaps and consumer back-pressure
    rand_ready = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      int n;
      n = (g % 100 == 50) ? int'($urandom_range(250, 260)) : int'($urandom_range(1, 6));
      ops_q.delete();
      for (int i = 0; i < n; i++) ops_q.push_back(IW'($urandom));
      send_group(1, (n < 10), 1);
    end
    wait_drain();
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
